// File: rtl/regfile_id_ex_pipe.sv
// regfile_id_ex_pipe
// Register file fused with the ID/EX pipeline register and the load-use
// hazard unit. Decodes rs/rt/rd/imm from the IF/ID word, reads two operands
// with a same-cycle writeback bypass, and latches everything into ID/EX.
// EX back-pressure holds ID/EX, a branch mispredict turns the incoming
// instruction into a bubble, and a load-use dependency inserts one bubble
// while freezing fetch.
module regfile_id_ex_pipe #(
  parameter int DATA_W    = 32,
  parameter int NREG      = 32,
  parameter int CTRL_W    = 13,
  parameter int MEMRD_BIT = 2,
  parameter int PRED_W    = 2,
  parameter int PRED_RST  = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       if_id_instr,
  input  logic              if_id_valid,
  input  logic [CTRL_W-1:0] if_id_ctrl,
  input  logic [PRED_W-1:0] if_id_pred,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_rd,
  input  logic              wb_mem_to_reg,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_mem_data,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic [AW-1:0]     id_ex_rs,
  output logic [AW-1:0]     id_ex_rt,
  output logic [AW-1:0]     id_ex_rd,
  output logic [DATA_W-1:0] id_ex_rdata1,
  output logic [DATA_W-1:0] id_ex_rdata2,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [PRED_W-1:0] id_ex_pred
);

  // Architectural register storage; entry 0 is never written.
  logic [DATA_W-1:0] regs_r [NREG];

  // ID/EX state
  logic              id_ex_valid_r;
  logic [CTRL_W-1:0] id_ex_ctrl_r;
  logic [AW-1:0]     id_ex_rs_r;
  logic [AW-1:0]     id_ex_rt_r;
  logic [AW-1:0]     id_ex_rd_r;
  logic [DATA_W-1:0] id_ex_rdata1_r;
  logic [DATA_W-1:0] id_ex_rdata2_r;
  logic [DATA_W-1:0] id_ex_imm_r;
  logic [PRED_W-1:0] id_ex_pred_r;

  // Decode / read-side combinational signals
  logic [AW-1:0]     rs_s;
  logic [AW-1:0]     rt_s;
  logic [AW-1:0]     rd_s;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] wb_data_s;
  logic [DATA_W-1:0] rdata1_s;
  logic [DATA_W-1:0] rdata2_s;
  logic              hz_s;
  logic              release_s;
  logic              load_fields_s;
  logic              refresh1_s;
  logic              refresh2_s;
  logic              unused_opcode_s;

  // Field extraction: only the low AW bits of each 5-bit index are used,
  // so with a smaller register file higher indices alias onto low ones.
  assign rs_s  = if_id_instr[21 +: AW];
  assign rt_s  = if_id_instr[16 +: AW];
  assign rd_s  = if_id_instr[11 +: AW];
  assign imm_s = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};

  // The opcode is decoded upstream into if_id_ctrl.
  assign unused_opcode_s = ^if_id_instr[31:26];

  // Writeback value selection between load data and ALU result.
  always_comb begin
    wb_data_s = wb_alu_result;
    if (wb_mem_to_reg) begin
      wb_data_s = wb_mem_data;
    end else begin
      wb_data_s = wb_alu_result;
    end
  end

  assign wb_write_data = wb_data_s;

  // Operand 1 read: r0 is hard zero, a same-cycle write is bypassed.
  always_comb begin
    rdata1_s = '0;
    if (rs_s == '0) begin
      rdata1_s = '0;
    end else if (wb_we && (wb_rd == rs_s)) begin
      rdata1_s = wb_data_s;
    end else begin
      rdata1_s = regs_r[rs_s];
    end
  end

  // Operand 2 read: same rules as operand 1.
  always_comb begin
    rdata2_s = '0;
    if (rt_s == '0) begin
      rdata2_s = '0;
    end else if (wb_we && (wb_rd == rt_s)) begin
      rdata2_s = wb_data_s;
    end else begin
      rdata2_s = regs_r[rt_s];
    end
  end

  // Load-use hazard: a load sitting in ID/EX whose destination feeds the
  // instruction now in IF/ID. A load to r0 never creates a dependency.
  always_comb begin
    hz_s = 1'b0;
    if (id_ex_valid_r && id_ex_ctrl_r[MEMRD_BIT] && (id_ex_rt_r != '0) &&
        if_id_valid && ((id_ex_rt_r == rs_s) || (id_ex_rt_r == rt_s))) begin
      hz_s = 1'b1;
    end else begin
      hz_s = 1'b0;
    end
  end

  // Fetch is released by a flush even while EX is stalled, because the
  // wrong-path instruction in IF/ID has to be replaced.
  assign release_s   = flush | ~(ex_stall | hz_s);
  assign pc_write    = release_s;
  assign if_id_write = release_s;

  // Non-control ID/EX fields load on every cycle except a plain stall.
  assign load_fields_s = flush | ~ex_stall;

  // While ID/EX is held, a writeback to one of its source registers must
  // update the held operand so EX never consumes a stale value.
  assign refresh1_s = wb_we && (wb_rd == id_ex_rs_r) && (id_ex_rs_r != '0);
  assign refresh2_s = wb_we && (wb_rd == id_ex_rt_r) && (id_ex_rt_r != '0);

  // Register file write port; independent of stall, flush and hazard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_we && (wb_rd != '0)) begin
      regs_r[wb_rd] <= wb_data_s;
    end
  end

  // ID/EX valid and control: flush and hazard both produce a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_valid_r <= 1'b0;
      id_ex_ctrl_r  <= '0;
    end else if (flush) begin
      id_ex_valid_r <= 1'b0;
      id_ex_ctrl_r  <= '0;
    end else if (ex_stall) begin
      id_ex_valid_r <= id_ex_valid_r;
      id_ex_ctrl_r  <= id_ex_ctrl_r;
    end else if (hz_s) begin
      id_ex_valid_r <= 1'b0;
      id_ex_ctrl_r  <= '0;
    end else begin
      id_ex_valid_r <= if_id_valid;
      id_ex_ctrl_r  <= if_id_valid ? if_id_ctrl : {CTRL_W{1'b0}};
    end
  end

  // ID/EX indices, immediate and predictor state: load or hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_rs_r   <= '0;
      id_ex_rt_r   <= '0;
      id_ex_rd_r   <= '0;
      id_ex_imm_r  <= '0;
      id_ex_pred_r <= PRED_W'(PRED_RST);
    end else if (load_fields_s) begin
      id_ex_rs_r   <= rs_s;
      id_ex_rt_r   <= rt_s;
      id_ex_rd_r   <= rd_s;
      id_ex_imm_r  <= imm_s;
      id_ex_pred_r <= if_id_pred;
    end
  end

  // ID/EX operands: load, or while held pick up writebacks to the sources.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_rdata1_r <= '0;
      id_ex_rdata2_r <= '0;
    end else if (load_fields_s) begin
      id_ex_rdata1_r <= rdata1_s;
      id_ex_rdata2_r <= rdata2_s;
    end else begin
      if (refresh1_s) begin
        id_ex_rdata1_r <= wb_data_s;
      end
      if (refresh2_s) begin
        id_ex_rdata2_r <= wb_data_s;
      end
    end
  end

  assign id_ex_valid  = id_ex_valid_r;
  assign id_ex_ctrl   = id_ex_ctrl_r;
  assign id_ex_rs     = id_ex_rs_r;
  assign id_ex_rt     = id_ex_rt_r;
  assign id_ex_rd     = id_ex_rd_r;
  assign id_ex_rdata1 = id_ex_rdata1_r;
  assign id_ex_rdata2 = id_ex_rdata2_r;
  assign id_ex_imm    = id_ex_imm_r;
  assign id_ex_pred   = id_ex_pred_r;

endmodule

// File: tb/tb_regfile_id_ex_pipe.sv
// Bench for regfile_id_ex_pipe: a 32-register instance plus a 16-register
// instance sharing the same stimulus (for index aliasing). Expected ID/EX
// contents are queued when a cycle is driven and compared after the edge.
`timescale 1ns/1ps
module tb_regfile_id_ex_pipe;

  localparam int S_VALID = 0, S_CTRL = 1, S_RS = 2, S_RT = 3, S_RD = 4,
                 S_RD1 = 5, S_RD2 = 6, S_IMM = 7, S_PRED = 8,
                 S16_RS = 9, S16_RD1 = 10;

  typedef struct {
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [12:0] if_id_ctrl;
  logic [1:0]  if_id_pred;
  logic        ex_stall, flush, wb_we, wb_mem_to_reg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_result, wb_mem_data;

  logic [31:0] wb_write_data;
  logic        pc_write, if_id_write, id_ex_valid;
  logic [12:0] id_ex_ctrl;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic [31:0] id_ex_rdata1, id_ex_rdata2, id_ex_imm;
  logic [1:0]  id_ex_pred;

  logic [31:0] wb_write_data16;
  logic        pc_write16, if_id_write16, id_ex_valid16;
  logic [12:0] id_ex_ctrl16;
  logic [3:0]  id_ex_rs16, id_ex_rt16, id_ex_rd16;
  logic [31:0] id_ex_rdata1_16, id_ex_rdata2_16, id_ex_imm16;
  logic [1:0]  id_ex_pred16;

  always #5 clk = ~clk;

  regfile_id_ex_pipe dut (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .if_id_ctrl(if_id_ctrl), .if_id_pred(if_id_pred), .ex_stall(ex_stall), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_write_data(wb_write_data), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_valid(id_ex_valid), .id_ex_ctrl(id_ex_ctrl), .id_ex_rs(id_ex_rs),
    .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_rdata1(id_ex_rdata1),
    .id_ex_rdata2(id_ex_rdata2), .id_ex_imm(id_ex_imm), .id_ex_pred(id_ex_pred)
  );

  regfile_id_ex_pipe #(.NREG(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .if_id_ctrl(if_id_ctrl), .if_id_pred(if_id_pred), .ex_stall(ex_stall), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd[3:0]), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_write_data(wb_write_data16), .pc_write(pc_write16), .if_id_write(if_id_write16),
    .id_ex_valid(id_ex_valid16), .id_ex_ctrl(id_ex_ctrl16), .id_ex_rs(id_ex_rs16),
    .id_ex_rt(id_ex_rt16), .id_ex_rd(id_ex_rd16), .id_ex_rdata1(id_ex_rdata1_16),
    .id_ex_rdata2(id_ex_rdata2_16), .id_ex_imm(id_ex_imm16), .id_ex_pred(id_ex_pred16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic string sel_name(int sel);
    case (sel)
      S_VALID: return "id_ex_valid";
      S_CTRL:  return "id_ex_ctrl";
      S_RS:    return "id_ex_rs";
      S_RT:    return "id_ex_rt";
      S_RD:    return "id_ex_rd";
      S_RD1:   return "id_ex_rdata1";
      S_RD2:   return "id_ex_rdata2";
      S_IMM:   return "id_ex_imm";
      S_PRED:  return "id_ex_pred";
      S16_RS:  return "nreg16_id_ex_rs";
      S16_RD1: return "nreg16_id_ex_rdata1";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [63:0] obs(int sel);
    case (sel)
      S_VALID: return {63'd0, id_ex_valid};
      S_CTRL:  return {51'd0, id_ex_ctrl};
      S_RS:    return {59'd0, id_ex_rs};
      S_RT:    return {59'd0, id_ex_rt};
      S_RD:    return {59'd0, id_ex_rd};
      S_RD1:   return {32'd0, id_ex_rdata1};
      S_RD2:   return {32'd0, id_ex_rdata2};
      S_IMM:   return {32'd0, id_ex_imm};
      S_PRED:  return {62'd0, id_ex_pred};
      S16_RS:  return {60'd0, id_ex_rs16};
      S16_RD1: return {32'd0, id_ex_rdata1_16};
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  task automatic expect_q(input int sel, input logic [63:0] v);
    exp_t e;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  // One clock: edge, settle, then drain the scoreboard against the outputs.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(sel_name(e.sel), obs(e.sel), e.exp);
    end
  endtask

  task automatic clr();
    if_id_instr = 32'd0; if_id_valid = 1'b0; if_id_ctrl = 13'd0; if_id_pred = 2'd0;
    ex_stall = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_mem_to_reg = 1'b0;
    wb_alu_result = 32'd0; wb_mem_data = 32'd0;
  endtask

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {6'h00, rs, rt, rd, 11'h000};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic wb(input logic [4:0] rd, input logic m2r, input logic [31:0] alu,
                    input logic [31:0] mem);
    wb_we = 1'b1; wb_rd = rd; wb_mem_to_reg = m2r; wb_alu_result = alu; wb_mem_data = mem;
  endtask

  task automatic instr(input logic [31:0] w, input logic [12:0] c, input logic [1:0] p);
    if_id_instr = w; if_id_valid = 1'b1; if_id_ctrl = c; if_id_pred = p;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    @(negedge clk);
    // T1: reset with random inputs for two cycles
    repeat (2) begin
      if_id_instr = $urandom; if_id_valid = 1'($urandom); if_id_ctrl = 13'($urandom);
      if_id_pred = 2'($urandom); ex_stall = 1'($urandom); flush = 1'($urandom);
      wb_we = 1'b1; wb_rd = 5'($urandom_range(1, 31)); wb_mem_to_reg = 1'($urandom);
      wb_alu_result = $urandom; wb_mem_data = $urandom;
      cyc();
    end
    clr();
    #1;
    chk("reset_pc_write", {63'd0, pc_write}, 64'd1);
    chk("reset_if_id_write", {63'd0, if_id_write}, 64'd1);
    chk("reset_wb_write_data", {32'd0, wb_write_data}, 64'd0);
    expect_q(S_VALID, 0); expect_q(S_CTRL, 0); expect_q(S_RS, 0); expect_q(S_RT, 0);
    expect_q(S_RD, 0); expect_q(S_RD1, 0); expect_q(S_RD2, 0); expect_q(S_IMM, 0);
    expect_q(S_PRED, 1);
    cyc();
    rst_n = 1'b1;

    // C1: plain load, registers read zero after reset
    clr(); instr(rtype(5'd9, 5'd31, 5'd4), 13'h0001, 2'b10);
    #1; chk("c1_pc_write", {63'd0, pc_write}, 64'd1);
    expect_q(S_VALID, 1); expect_q(S_CTRL, 13'h0001); expect_q(S_RS, 9);
    expect_q(S_RT, 31); expect_q(S_RD, 4); expect_q(S_RD1, 0); expect_q(S_RD2, 0);
    expect_q(S_PRED, 2);
    cyc();

    // T2: same-cycle bypass of an ALU writeback
    clr(); instr(rtype(5'd5, 5'd6, 5'd1), 13'h0002, 2'b01);
    wb(5'd5, 1'b0, 32'hDEADBEEF, 32'h0BADF00D);
    #1; chk("t2_wb_write_data", {32'd0, wb_write_data}, 64'hDEADBEEF);
    expect_q(S_RD1, 64'hDEADBEEF); expect_q(S_RD2, 0); expect_q(S_PRED, 1);
    cyc();

    // Write to r0 is discarded and never bypassed; r5 now from the array
    clr(); instr(rtype(5'd0, 5'd5, 5'd2), 13'h0002, 2'b00);
    wb(5'd0, 1'b1, 32'h11111111, 32'h55AA55AA);
    #1; chk("r0_wb_write_data", {32'd0, wb_write_data}, 64'h55AA55AA);
    expect_q(S_RD1, 0); expect_q(S_RD2, 64'hDEADBEEF);
    cyc();

    // T3 setup: lw rt=3 with negative imm; also write r3=0x333
    clr(); instr(itype(6'h23, 5'd0, 5'd3, 16'h8001), 13'h0004, 2'b00);
    wb(5'd3, 1'b0, 32'h00000333, 32'h0);
    expect_q(S_VALID, 1); expect_q(S_CTRL, 13'h0004); expect_q(S_RT, 3);
    expect_q(S_IMM, 64'hFFFF8001);
    cyc();

    // T3: add rs=3 behind the load -> one bubble, fetch frozen
    clr(); instr(rtype(5'd3, 5'd4, 5'd2), 13'h0011, 2'b00);
    #1;
    chk("t3_pc_write", {63'd0, pc_write}, 64'd0);
    chk("t3_if_id_write", {63'd0, if_id_write}, 64'd0);
    expect_q(S_VALID, 0); expect_q(S_CTRL, 0);
    cyc();
    #1; chk("t3_release", {63'd0, pc_write}, 64'd1);
    expect_q(S_VALID, 1); expect_q(S_CTRL, 13'h0011); expect_q(S_RS, 3);
    expect_q(S_RD1, 64'h333);
    cyc();

    // T4 setup: instruction reading r7 and r3
    clr(); instr(rtype(5'd7, 5'd3, 5'd9), 13'h0021, 2'b11);
    expect_q(S_RS, 7); expect_q(S_RD1, 0); expect_q(S_RD2, 64'h333);
    cyc();

    // T4: stalled, writeback of r7 refreshes operand 1 only
    clr(); instr(rtype(5'd1, 5'd2, 5'd10), 13'h1FFF, 2'b00); ex_stall = 1'b1;
    wb(5'd7, 1'b0, 32'h12345678, 32'h0);
    #1; chk("t4_pc_write", {63'd0, pc_write}, 64'd0);
    expect_q(S_RD1, 64'h12345678); expect_q(S_RS, 7); expect_q(S_RT, 3);
    expect_q(S_RD, 9); expect_q(S_CTRL, 13'h0021); expect_q(S_VALID, 1);
    expect_q(S_RD2, 64'h333); expect_q(S_PRED, 3);
    cyc();

    // Still stalled: load-data writeback to r3 refreshes operand 2
    wb(5'd3, 1'b1, 32'h0, 32'hCAFEF00D);
    expect_q(S_RD2, 64'hCAFEF00D); expect_q(S_RD1, 64'h12345678);
    cyc();

    // T5: flush together with stall -> bubble, fetch released
    clr(); instr(itype(6'h04, 5'd1, 5'd2, 16'h0004), 13'h0100, 2'b10);
    ex_stall = 1'b1; flush = 1'b1;
    #1;
    chk("t5_pc_write", {63'd0, pc_write}, 64'd1);
    chk("t5_if_id_write", {63'd0, if_id_write}, 64'd1);
    expect_q(S_VALID, 0); expect_q(S_CTRL, 0); expect_q(S_RS, 1);
    expect_q(S_IMM, 64'h4);
    cyc();

    // T6: rs=0x13 is r19 with 32 regs, aliases r3 with 16 regs
    clr(); instr(rtype(5'h13, 5'h03, 5'd1), 13'h0001, 2'b00);
    expect_q(S_RS, 64'h13); expect_q(S_RD1, 0); expect_q(S_RD2, 64'hCAFEF00D);
    expect_q(S16_RS, 3); expect_q(S16_RD1, 64'hCAFEF00D);
    cyc();

    // Reset mid-stall overrides everything, then registers read zero
    clr(); instr(rtype(5'd5, 5'd7, 5'd1), 13'h0001, 2'b01); ex_stall = 1'b1;
    rst_n = 1'b0;
    expect_q(S_VALID, 0); expect_q(S_RS, 0); expect_q(S_PRED, 1); expect_q(S_RD1, 0);
    cyc();
    rst_n = 1'b1; ex_stall = 1'b0;
    expect_q(S_VALID, 1); expect_q(S_RS, 5); expect_q(S_RD1, 0); expect_q(S_RD2, 0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
